// File: rtl/mc_mem_responder.sv
// mc_mem_responder: wait-stated unified memory responder with instruction register for a multicycle core
// Ports: clk/rst (sync, active-high); req_valid/req_ready handshake with req_we, req_ir, req_addr, req_wdata;
//        resp_valid one-cycle pulse with resp_rdata; instr register and its opcode field; busy when not IDLE.
// Optional MC_MEM_RANGE_ERR_EN: adds resp_err and suppresses accesses to req_addr >= DEPTH instead of wrapping.
module mc_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_ir,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        opcode,
`ifdef MC_MEM_RANGE_ERR_EN
  output logic              resp_err,
`endif
  output logic              busy
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, idx;
  logic we_q, we_d, ir_q, ir_d, ok, access, mem_we;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, instr_q, instr_d, rd;
  logic [DATA_W-1:0] mem [DEPTH];
  // Out-of-range addresses fold back into the array unless range checking rejects them.
  assign idx = ADDR_W'(32'(addr_q) % DEPTH);
  assign rd = mem[idx];
`ifdef MC_MEM_RANGE_ERR_EN
  logic err_q, err_d;
  assign ok = 32'(addr_q) < DEPTH;
  assign err_d = access ? !ok : err_q;
  assign resp_err = err_q;
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
`else
  assign ok = 1'b1;
`endif
  assign access = state_q == S_WAIT && cnt_q == 4'd0;
  assign mem_we = access && we_q && ok;
  assign req_ready = state_q == S_IDLE;
  assign busy = !req_ready;
  assign resp_valid = state_q == S_RESP;
  assign resp_rdata = rdata_q;
  assign instr = instr_q;
  assign opcode = instr_q[31:26];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    we_d = we_q;
    ir_d = ir_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d = req_addr;
        we_d = req_we;
        ir_d = req_ir;
        wdata_d = req_wdata;
        cnt_d = 4'(WAIT_CYCLES);
        state_d = S_WAIT;
      end
      S_WAIT: if (access) begin
        rdata_d = !ok ? '0 : we_q ? wdata_q : rd;
        instr_d = (ok && !we_q && ir_q) ? rd : instr_q;
        state_d = S_RESP;
      end else cnt_d = cnt_q - 4'd1;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      ir_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      we_q <= we_d;
      ir_q <= ir_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      instr_q <= instr_d;
    end
  end
  // A reset on the committing edge abandons the store.
  always_ff @(posedge clk) if (!rst && mem_we) mem[idx] <= wdata_q;
endmodule

// File: tb/tb_mc_mem_responder.sv
// tb_mc_mem_responder: directed table-driven bench for mc_mem_responder (DEPTH=200, WAIT_CYCLES=2)
module tb_mc_mem_responder;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_ready, req_we = 1'b0, req_ir = 1'b0;
  logic [7:0] req_addr = '0;
  logic [31:0] req_wdata = '0, resp_rdata, instr;
  logic resp_valid, busy;
  logic [5:0] opcode;
`ifdef MC_MEM_RANGE_ERR_EN
  logic resp_err;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mc_mem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ir(req_ir), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .instr(instr), .opcode(opcode),
`ifdef MC_MEM_RANGE_ERR_EN
    .resp_err(resp_err),
`endif
    .busy(busy));
  typedef struct {
    logic we, ir, err;
    logic [7:0] addr;
    logic [31:0] wdata, rdata, instr;
  } vec_t;
  vec_t v[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic start(input logic we, input logic ir, input logic [7:0] addr, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we = we;
    req_ir = ir;
    req_addr = addr;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  task automatic wait_resp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
  endtask
  task automatic xact(input logic we, input logic ir, input logic [7:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat);
    start(we, ir, addr, wd);
    wait_resp(lat);
    rd = resp_rdata;
  endtask
  initial begin
    logic [31:0] rd;
    int lat;
    bit seen;
    v[0]  = '{1'b1, 1'b0, 1'b0, 8'd4,   32'h20080005, 32'h20080005, 32'h00000000};
    v[1]  = '{1'b1, 1'b0, 1'b0, 8'd5,   32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000};
    v[2]  = '{1'b0, 1'b1, 1'b0, 8'd4,   32'h0,        32'h20080005, 32'h20080005};
    v[3]  = '{1'b0, 1'b0, 1'b0, 8'd5,   32'h0,        32'hDEADBEEF, 32'h20080005};
    v[4]  = '{1'b1, 1'b0, 1'b0, 8'd9,   32'h11111111, 32'h11111111, 32'h20080005};
    v[5]  = '{1'b1, 1'b0, 1'b0, 8'd50,  32'hCAFE0050, 32'hCAFE0050, 32'h20080005};
    v[6]  = '{1'b1, 1'b1, 1'b0, 8'd199, 32'h000000C7, 32'h000000C7, 32'h20080005};
`ifdef MC_MEM_RANGE_ERR_EN
    v[7]  = '{1'b0, 1'b1, 1'b1, 8'd250, 32'h0,        32'h00000000, 32'h20080005};
`else
    v[7]  = '{1'b0, 1'b0, 1'b0, 8'd250, 32'h0,        32'hCAFE0050, 32'h20080005};
`endif
    v[8]  = '{1'b0, 1'b1, 1'b0, 8'd199, 32'h0,        32'h000000C7, 32'h000000C7};
`ifdef MC_MEM_RANGE_ERR_EN
    v[9]  = '{1'b1, 1'b0, 1'b1, 8'd250, 32'h12345678, 32'h00000000, 32'h000000C7};
    v[10] = '{1'b0, 1'b0, 1'b0, 8'd50,  32'h0,        32'hCAFE0050, 32'h000000C7};
`else
    v[9]  = '{1'b1, 1'b0, 1'b0, 8'd250, 32'h12345678, 32'h12345678, 32'h000000C7};
    v[10] = '{1'b0, 1'b0, 1'b0, 8'd50,  32'h0,        32'h12345678, 32'h000000C7};
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 11; i++) begin
      xact(v[i].we, v[i].ir, v[i].addr, v[i].wdata, rd, lat);
      chk($sformatf("lat[%0d]", i), 32'(lat), 32'd4);
      chk($sformatf("rdata[%0d]", i), rd, v[i].rdata);
      chk($sformatf("instr[%0d]", i), instr, v[i].instr);
      chk($sformatf("opcode[%0d]", i), 32'(opcode), 32'(v[i].instr[31:26]));
`ifdef MC_MEM_RANGE_ERR_EN
      chk($sformatf("err[%0d]", i), 32'(resp_err), 32'(v[i].err));
`endif
      if (i == 2) chk("opcode_fetch", 32'(opcode), 32'h08);
    end
    // Requester holds req_valid while the address keeps changing during WAIT/RESP.
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_ir = 1'b0;
    req_addr = 8'd4;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_addr = 8'd5;
      chk($sformatf("hold_ready[%0d]", k), 32'(req_ready), 32'd0);
      chk($sformatf("hold_busy[%0d]", k), 32'(busy), 32'd1);
    end
    chk("hold_resp_valid", 32'(resp_valid), 32'd1);
    chk("hold_rdata", resp_rdata, 32'h20080005);
    @(negedge clk);
    chk("hold_idle_ready", 32'(req_ready), 32'd1);
    chk("hold_idle_resp", 32'(resp_valid), 32'd0);
    chk("hold_rdata_kept", resp_rdata, 32'h20080005);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(lat);
    chk("hold2_lat", 32'(lat), 32'd4);
    chk("hold2_rdata", resp_rdata, 32'hDEADBEEF);
    // Reset in the first WAIT cycle abandons a write.
    start(1'b1, 1'b0, 8'd9, 32'hAAAAAAAA);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    chk("rst1_no_resp", 32'(seen), 32'd0);
    chk("rst1_idle", 32'(busy), 32'd0);
    chk("rst1_rdata", resp_rdata, 32'd0);
    // Reset on the edge leaving WAIT also abandons the write.
    start(1'b1, 1'b0, 8'd9, 32'hBBBBBBBB);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    chk("rst2_no_resp", 32'(seen), 32'd0);
    chk("rst2_instr", instr, 32'd0);
    xact(1'b0, 1'b0, 8'd9, 32'h0, rd, lat);
    chk("rst_read_lat", 32'(lat), 32'd4);
    chk("rst_read_9", rd, 32'h11111111);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
